// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// The fetch FSM state encoding, the PC step/hold constants and the bubble encoding live here.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  // One instruction word.
  localparam logic [31:0] INSTR_BYTES  = 32'd4;

  // The PC register loads pc_next-8 when pc_write=0. Presenting pc_in+8 on a hold
  // therefore keeps the PC unchanged.
  localparam logic [31:0] PC_HOLD_COMP = 32'd8;

  // Value written into IF/ID on a flush.
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

  // Counter increment that sticks at all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register with a one-entry skid buffer.
// A response that lands while decode is stalled is parked in the skid buffer.
// It is handed to IF/ID on the first unstalled cycle.
// A flush clears both the register and the skid buffer.
module ifid_reg
  import fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        stall_i,
  input  logic        cap_i,
  input  logic [31:0] cap_data_i,
  input  logic [31:0] pc4_i,
  output logic        skid_vld_o,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc4_o
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        skid_vld_q, skid_vld_d;
  logic [31:0] skid_data_q, skid_data_d;

  // Next-state: flush > stall (hold, maybe park) > fresh data > skid data > bubble.
  always_comb begin
    valid_d     = valid_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    if (flush_i) begin
      valid_d     = 1'b0;
      instr_d     = NOP_INSTR;
      skid_vld_d  = 1'b0;
      skid_data_d = NOP_INSTR;
    end else if (stall_i) begin
      if (cap_i) begin
        skid_vld_d  = 1'b1;
        skid_data_d = cap_data_i;
      end
    end else if (cap_i) begin
      valid_d = 1'b1;
      instr_d = cap_data_i;
      pc4_d   = pc4_i;
    end else if (skid_vld_q) begin
      valid_d    = 1'b1;
      instr_d    = skid_data_q;
      pc4_d      = pc4_i;
      skid_vld_d = 1'b0;
    end else begin
      // No new instruction: insert a bubble so decode never sees a duplicate.
      valid_d = 1'b0;
    end
  end

  // State registers; reset empties both IF/ID and the skid buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      instr_q     <= '0;
      pc4_q       <= '0;
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
    end else begin
      valid_q     <= valid_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign skid_vld_o   = skid_vld_q;
  assign ifid_valid_o = valid_q;
  assign ifid_instr_o = instr_q;
  assign ifid_pc4_o   = pc4_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: boot, request/wait FSM, PC steering and redirect handling.
// There is at most one outstanding instruction-memory read.
// The PC register is external; pc_write=0 means "load pc_next-8", so holds present pc_in+8.
// Optional: define FETCH_PERF_CNT_EN to add the saturating counters cnt_fetch/cnt_stall/cnt_flush.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_in,
  output logic [31:0] pc_next,
  output logic        pc_write,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] cnt_fetch,
  output logic [31:0] cnt_stall,
  output logic [31:0] cnt_flush
`endif
);

  fetch_state_e state_q, state_d;

  logic [31:0] pc_plus4;
  logic [31:0] pc_hold;
  logic [31:0] pc_next_c;
  logic        pc_write_c;
  logic        req_c;
  logic        skid_vld;
  logic        cap;
  logic        deliver;

  assign pc_plus4 = pc_in + INSTR_BYTES;
  assign pc_hold  = pc_in + PC_HOLD_COMP;

  // A response is accepted only in WAIT. A same-cycle redirect discards it.
  assign cap     = (state_q == WAIT) && imem_rvalid && !redirect_valid;
  // An instruction reaches IF/ID this cycle from the bus or from the skid buffer.
  assign deliver = !redirect_valid && !stall && (imem_rvalid || skid_vld);

  // State register; reset returns to BOOT immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BOOT;
    else        state_q <= state_d;
  end

  // Next-state and PC/request outputs; default is a PC hold with no request.
  always_comb begin
    state_d    = state_q;
    pc_next_c  = pc_hold;
    pc_write_c = 1'b0;
    req_c      = 1'b0;
    case (state_q)
      BOOT: begin
        state_d    = REQ;
        pc_write_c = 1'b1;
        pc_next_c  = redirect_valid ? redirect_target : RESET_PC;
      end
      REQ: begin
        if (redirect_valid) begin
          // The request is suppressed so the new target is fetched next cycle.
          pc_next_c  = redirect_target;
          pc_write_c = 1'b1;
        end else if (!stall) begin
          req_c   = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_next_c  = redirect_target;
          pc_write_c = 1'b1;
          // Drain only if the read is still in flight; a returning or parked response
          // means nothing is outstanding any more.
          state_d    = (imem_rvalid || skid_vld) ? REQ : DRAIN;
        end else if (deliver) begin
          pc_next_c  = pc_plus4;
          pc_write_c = 1'b1;
          state_d    = REQ;
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          pc_next_c  = redirect_target;
          pc_write_c = 1'b1;
        end
        // The first response in DRAIN belongs to the abandoned path and is dropped.
        if (imem_rvalid) state_d = REQ;
      end
      default: state_d = BOOT;
    endcase
  end

  // While reset is held, the PC outputs show zero instead of the BOOT values.
  assign pc_next   = rst_n ? pc_next_c : '0;
  assign pc_write  = rst_n & pc_write_c;
  assign imem_req  = req_c;
  assign imem_addr = req_c ? pc_in : '0;

  ifid_reg u_ifid (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (redirect_valid),
    .stall_i      (stall),
    .cap_i        (cap),
    .cap_data_i   (imem_rdata),
    .pc4_i        (pc_plus4),
    .skid_vld_o   (skid_vld),
    .ifid_valid_o (ifid_valid),
    .ifid_instr_o (ifid_instr),
    .ifid_pc4_o   (ifid_pc4)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] cnt_fetch_q, cnt_stall_q, cnt_flush_q;

  // Saturating event counters: delivered instructions, stalled cycles, redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_fetch_q <= '0;
      cnt_stall_q <= '0;
      cnt_flush_q <= '0;
    end else begin
      if ((state_q == WAIT) && deliver) cnt_fetch_q <= sat_inc(cnt_fetch_q);
      if (stall)                        cnt_stall_q <= sat_inc(cnt_stall_q);
      if (redirect_valid)               cnt_flush_q <= sat_inc(cnt_flush_q);
    end
  end

  assign cnt_fetch = cnt_fetch_q;
  assign cnt_stall = cnt_stall_q;
  assign cnt_flush = cnt_flush_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl.
// It models the external PC register and a fixed-latency instruction memory that returns ~addr.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_in;
  logic [31:0] pc_next;
  logic        pc_write;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] cnt_fetch, cnt_stall, cnt_flush;
`endif

  int total = 0;
  int bad   = 0;
  int mem_lat = 1;
  logic [31:0] pc_q = 32'h0;

  always #5 clk = ~clk;

  // External PC register: the hold encoding means pc_write=0 loads pc_next-8.
  always @(posedge clk) pc_q <= pc_write ? pc_next : pc_next - 32'd8;
  assign pc_in = pc_q;

  fetch_ctrl #(.RESET_PC(32'h100)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_in           (pc_in),
    .pc_next         (pc_next),
    .pc_write        (pc_write),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .ifid_valid      (ifid_valid),
    .ifid_instr      (ifid_instr),
    .ifid_pc4        (ifid_pc4)
`ifdef FETCH_PERF_CNT_EN
    ,
    .cnt_fetch       (cnt_fetch),
    .cnt_stall       (cnt_stall),
    .cnt_flush       (cnt_flush)
`endif
  );

  // Memory responder: latency mem_lat cycles; data = ~addr. It also checks the single-outstanding rule.
  initial begin : mem
    logic        req_s;
    logic [31:0] addr_s;
    logic [31:0] maddr;
    int          cnt;
    bit          pend;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    pend  = 1'b0;
    cnt   = 0;
    maddr = 32'h0;
    forever begin
      @(negedge clk);
      req_s  = imem_req;
      addr_s = imem_addr;
      @(posedge clk); #1;
      imem_rvalid = 1'b0;
      if (req_s === 1'b1) begin
        total++;
        if (pend) begin bad++; $display("FAIL one_outstanding got=req@%h while %h pending", addr_s, maddr); end
        pend  = 1'b1;
        cnt   = mem_lat;
        maddr = addr_s;
      end
      if (pend) begin
        cnt--;
        if (cnt <= 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = ~maddr;
          pend        = 1'b0;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Waits for ifid_valid and stops at the negedge where it is seen.
  task automatic wait_ifid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ifid_valid === 1'b1) begin ok = 1'b1; return; end
      cyc();
    end
  endtask

  // Redirects to t and stops at the negedge of the REQ cycle that issues t.
  task automatic goto(input logic [31:0] t, output bit ok);
    ok = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = t;
    cyc();
    redirect_valid  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (imem_req === 1'b1 && imem_addr === t) begin ok = 1'b1; return; end
      cyc();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0; mem_lat = 1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    total++; if (imem_req !== 1'b0)        begin bad++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    total++; if (ifid_valid !== 1'b0)      begin bad++; $display("FAIL rst_valid got=%b exp=0", ifid_valid); end
    total++; if (ifid_instr !== 32'h0)     begin bad++; $display("FAIL rst_instr got=%h exp=0", ifid_instr); end
    total++; if (ifid_pc4 !== 32'h0)       begin bad++; $display("FAIL rst_pc4 got=%h exp=0", ifid_pc4); end
    total++; if (pc_write !== 1'b0)        begin bad++; $display("FAIL rst_pc_write got=%b exp=0", pc_write); end
    total++; if (pc_next !== 32'h0)        begin bad++; $display("FAIL rst_pc_next got=%h exp=0", pc_next); end
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (pc_write !== 1'b1)        begin bad++; $display("FAIL boot_pc_write got=%b exp=1", pc_write); end
    total++; if (pc_next !== 32'h100)      begin bad++; $display("FAIL boot_pc_next got=%h exp=100", pc_next); end
    cyc();
  endtask

  task automatic test_boot();
    bit ok;
    logic [31:0] a;
    @(negedge clk);
    total++; if (imem_req !== 1'b1)        begin bad++; $display("FAIL boot_req got=%b exp=1", imem_req); end
    total++; if (imem_addr !== 32'h100)    begin bad++; $display("FAIL boot_addr got=%h exp=100", imem_addr); end
    total++; if (pc_write !== 1'b0)        begin bad++; $display("FAIL req_hold_write got=%b exp=0", pc_write); end
    total++; if (pc_next !== 32'h108)      begin bad++; $display("FAIL req_hold_next got=%h exp=108", pc_next); end
    cyc();
    for (int k = 0; k < 3; k++) begin
      a = 32'h100 + 32'(4 * k);
      wait_ifid(ok);
      total++; if (ok !== 1'b1)             begin bad++; $display("FAIL boot_fetch%0d got=timeout exp=valid", k); end
      total++; if (ifid_pc4 !== a + 32'd4)  begin bad++; $display("FAIL boot_pc4_%0d got=%h exp=%h", k, ifid_pc4, a + 32'd4); end
      total++; if (ifid_instr !== ~a)       begin bad++; $display("FAIL boot_instr_%0d got=%h exp=%h", k, ifid_instr, ~a); end
      cyc();
    end
  endtask

  task automatic test_stall();
    bit ok;
    mem_lat = 3;
    goto(32'h300, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL stall_goto got=timeout exp=req"); end
    cyc();                       // WAIT 1
    cyc(); stall = 1'b1;         // WAIT 2, stalled
    @(negedge clk);
    total++; if (pc_write !== 1'b0)        begin bad++; $display("FAIL stall_w1 got=%b exp=0", pc_write); end
    total++; if (pc_next !== 32'h308)      begin bad++; $display("FAIL stall_n1 got=%h exp=308", pc_next); end
    cyc();                       // response arrives while stalled
    @(negedge clk);
    total++; if (pc_write !== 1'b0)        begin bad++; $display("FAIL stall_w2 got=%b exp=0", pc_write); end
    total++; if (pc_next !== 32'h308)      begin bad++; $display("FAIL stall_n2 got=%h exp=308", pc_next); end
    total++; if (ifid_valid !== 1'b0)      begin bad++; $display("FAIL stall_v2 got=%b exp=0", ifid_valid); end
    cyc();
    @(negedge clk);
    total++; if (imem_req !== 1'b0)        begin bad++; $display("FAIL stall_req3 got=%b exp=0", imem_req); end
    total++; if (ifid_valid !== 1'b0)      begin bad++; $display("FAIL stall_v3 got=%b exp=0", ifid_valid); end
    total++; if (pc_in !== 32'h300)        begin bad++; $display("FAIL stall_pc_held got=%h exp=300", pc_in); end
    cyc(); stall = 1'b0;         // first unstalled cycle: skid delivers
    @(negedge clk);
    total++; if (pc_write !== 1'b1)        begin bad++; $display("FAIL skid_w got=%b exp=1", pc_write); end
    total++; if (pc_next !== 32'h304)      begin bad++; $display("FAIL skid_n got=%h exp=304", pc_next); end
    cyc();
    @(negedge clk);
    total++; if (ifid_valid !== 1'b1)      begin bad++; $display("FAIL skid_v got=%b exp=1", ifid_valid); end
    total++; if (ifid_instr !== ~32'h300)  begin bad++; $display("FAIL skid_instr got=%h exp=%h", ifid_instr, ~32'h300); end
    total++; if (ifid_pc4 !== 32'h304)     begin bad++; $display("FAIL skid_pc4 got=%h exp=304", ifid_pc4); end
    total++; if (imem_addr !== 32'h304)    begin bad++; $display("FAIL skid_next_addr got=%h exp=304", imem_addr); end
    cyc();
    @(negedge clk);
    total++; if (ifid_valid !== 1'b0)      begin bad++; $display("FAIL skid_dup got=%b exp=0", ifid_valid); end
    cyc();
    wait_ifid(ok);
    total++; if (ok !== 1'b1)              begin bad++; $display("FAIL stall_next got=timeout exp=valid"); end
    total++; if (ifid_pc4 !== 32'h308)     begin bad++; $display("FAIL stall_next_pc4 got=%h exp=308", ifid_pc4); end
    total++; if (ifid_instr !== ~32'h304)  begin bad++; $display("FAIL stall_next_instr got=%h exp=%h", ifid_instr, ~32'h304); end
    cyc();
  endtask

  task automatic test_redirect_wait();
    bit ok;
    mem_lat = 4;
    goto(32'h40, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL rdw_goto got=timeout exp=req"); end
    cyc();
    cyc(); redirect_valid = 1'b1; redirect_target = 32'h200;
    @(negedge clk);
    total++; if (pc_next !== 32'h200)      begin bad++; $display("FAIL rdw_next got=%h exp=200", pc_next); end
    total++; if (pc_write !== 1'b1)        begin bad++; $display("FAIL rdw_write got=%b exp=1", pc_write); end
    cyc(); redirect_valid = 1'b0;        // DRAIN
    @(negedge clk);
    total++; if (imem_req !== 1'b0)        begin bad++; $display("FAIL rdw_drain_req got=%b exp=0", imem_req); end
    total++; if (ifid_valid !== 1'b0)      begin bad++; $display("FAIL rdw_flush got=%b exp=0", ifid_valid); end
    total++; if (pc_next !== 32'h208)      begin bad++; $display("FAIL rdw_drain_hold got=%h exp=208", pc_next); end
    cyc();                               // stale response dropped
    @(negedge clk);
    total++; if (imem_req !== 1'b0)        begin bad++; $display("FAIL rdw_drop_req got=%b exp=0", imem_req); end
    cyc();
    @(negedge clk);
    total++; if (imem_req !== 1'b1)        begin bad++; $display("FAIL rdw_req got=%b exp=1", imem_req); end
    total++; if (imem_addr !== 32'h200)    begin bad++; $display("FAIL rdw_addr got=%h exp=200", imem_addr); end
    total++; if (ifid_valid !== 1'b0)      begin bad++; $display("FAIL rdw_nodata got=%b exp=0", ifid_valid); end
    cyc();
    wait_ifid(ok);
    total++; if (ok !== 1'b1)              begin bad++; $display("FAIL rdw_fetch got=timeout exp=valid"); end
    total++; if (ifid_instr !== ~32'h200)  begin bad++; $display("FAIL rdw_instr got=%h exp=%h", ifid_instr, ~32'h200); end
    total++; if (ifid_pc4 !== 32'h204)     begin bad++; $display("FAIL rdw_pc4 got=%h exp=204", ifid_pc4); end
    cyc();
  endtask

  task automatic test_redirect_rvalid();
    bit ok;
    mem_lat = 2;
    goto(32'h80, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL rdv_goto got=timeout exp=req"); end
    cyc();
    cyc(); redirect_valid = 1'b1; redirect_target = 32'h500;   // same cycle as rvalid
    @(negedge clk);
    total++; if (pc_next !== 32'h500)      begin bad++; $display("FAIL rdv_next got=%h exp=500", pc_next); end
    total++; if (pc_write !== 1'b1)        begin bad++; $display("FAIL rdv_write got=%b exp=1", pc_write); end
    cyc(); redirect_valid = 1'b0;
    @(negedge clk);
    total++; if (imem_req !== 1'b1)        begin bad++; $display("FAIL rdv_req got=%b exp=1", imem_req); end
    total++; if (imem_addr !== 32'h500)    begin bad++; $display("FAIL rdv_addr got=%h exp=500", imem_addr); end
    total++; if (ifid_valid !== 1'b0)      begin bad++; $display("FAIL rdv_drop got=%b exp=0", ifid_valid); end
    cyc();
    wait_ifid(ok);
    total++; if (ok !== 1'b1)              begin bad++; $display("FAIL rdv_fetch got=timeout exp=valid"); end
    total++; if (ifid_instr !== ~32'h500)  begin bad++; $display("FAIL rdv_instr got=%h exp=%h", ifid_instr, ~32'h500); end
    cyc();
  endtask

  task automatic test_drain_redirect();
    bit ok;
    mem_lat = 4;
    goto(32'h600, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL dr2_goto got=timeout exp=req"); end
    cyc(); redirect_valid = 1'b1; redirect_target = 32'h700;   // WAIT -> DRAIN
    cyc(); redirect_target = 32'h800;                          // second redirect in DRAIN
    @(negedge clk);
    total++; if (pc_next !== 32'h800)      begin bad++; $display("FAIL dr2_next got=%h exp=800", pc_next); end
    total++; if (pc_write !== 1'b1)        begin bad++; $display("FAIL dr2_write got=%b exp=1", pc_write); end
    cyc(); redirect_valid = 1'b0;
    @(negedge clk);
    total++; if (imem_req !== 1'b0)        begin bad++; $display("FAIL dr2_stay got=%b exp=0", imem_req); end
    total++; if (pc_next !== 32'h808)      begin bad++; $display("FAIL dr2_hold got=%h exp=808", pc_next); end
    cyc();
    @(negedge clk);
    total++; if (imem_req !== 1'b0)        begin bad++; $display("FAIL dr2_drop got=%b exp=0", imem_req); end
    cyc();
    @(negedge clk);
    total++; if (imem_addr !== 32'h800 || imem_req !== 1'b1) begin bad++; $display("FAIL dr2_addr got=%b/%h exp=1/800", imem_req, imem_addr); end
    cyc();
  endtask

  task automatic test_redirect_stall();
    bit ok;
    mem_lat = 2;
    goto(32'h900, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL rds_goto got=timeout exp=req"); end
    cyc();
    cyc(); stall = 1'b1;                 // response parks in skid
    @(negedge clk);
    total++; if (pc_write !== 1'b0)        begin bad++; $display("FAIL rds_park got=%b exp=0", pc_write); end
    cyc(); redirect_valid = 1'b1; redirect_target = 32'hA00;
    @(negedge clk);
    total++; if (pc_next !== 32'hA00)      begin bad++; $display("FAIL rds_next got=%h exp=a00", pc_next); end
    total++; if (pc_write !== 1'b1)        begin bad++; $display("FAIL rds_write got=%b exp=1", pc_write); end
    cyc(); redirect_valid = 1'b0;        // REQ, still stalled
    @(negedge clk);
    total++; if (imem_req !== 1'b0)        begin bad++; $display("FAIL rds_noreq got=%b exp=0", imem_req); end
    total++; if (pc_next !== 32'hA08)      begin bad++; $display("FAIL rds_hold got=%h exp=a08", pc_next); end
    total++; if (ifid_valid !== 1'b0)      begin bad++; $display("FAIL rds_flush got=%b exp=0", ifid_valid); end
    cyc(); stall = 1'b0;
    @(negedge clk);
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'hA00) begin bad++; $display("FAIL rds_req got=%b/%h exp=1/a00", imem_req, imem_addr); end
    cyc();
    wait_ifid(ok);
    total++; if (ok !== 1'b1)              begin bad++; $display("FAIL rds_fetch got=timeout exp=valid"); end
    total++; if (ifid_instr !== ~32'hA00)  begin bad++; $display("FAIL rds_skid_clr got=%h exp=%h", ifid_instr, ~32'hA00); end
    total++; if (ifid_pc4 !== 32'hA04)     begin bad++; $display("FAIL rds_pc4 got=%h exp=a04", ifid_pc4); end
    cyc();
  endtask

  task automatic test_wrap();
    bit ok;
    mem_lat = 1;
    goto(32'hFFFF_FFFC, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL wrap_goto got=timeout exp=req"); end
    total++; if (pc_next !== 32'h4)        begin bad++; $display("FAIL wrap_hold got=%h exp=4", pc_next); end
    cyc();
    @(negedge clk);
    total++; if (pc_next !== 32'h0)        begin bad++; $display("FAIL wrap_next got=%h exp=0", pc_next); end
    total++; if (pc_write !== 1'b1)        begin bad++; $display("FAIL wrap_write got=%b exp=1", pc_write); end
    cyc();
    @(negedge clk);
    total++; if (ifid_valid !== 1'b1)      begin bad++; $display("FAIL wrap_valid got=%b exp=1", ifid_valid); end
    total++; if (ifid_pc4 !== 32'h0)       begin bad++; $display("FAIL wrap_pc4 got=%h exp=0", ifid_pc4); end
    total++; if (ifid_instr !== 32'h3)     begin bad++; $display("FAIL wrap_instr got=%h exp=3", ifid_instr); end
    total++; if (imem_addr !== 32'h0)      begin bad++; $display("FAIL wrap_addr got=%h exp=0", imem_addr); end
    cyc();
  endtask

  task automatic test_midreset();
    bit ok;
    mem_lat = 2;
    goto(32'hB00, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL mrst_goto got=timeout exp=req"); end
    cyc(); cyc(); cyc();
    @(negedge clk);
    total++; if (ifid_pc4 !== 32'hB04)     begin bad++; $display("FAIL mrst_pre got=%h exp=b04", ifid_pc4); end
    cyc();                               // WAIT for 0xB04, response in flight
    rst_n = 1'b0;
    #1;
    total++; if (imem_req !== 1'b0)        begin bad++; $display("FAIL mrst_req got=%b exp=0", imem_req); end
    total++; if (ifid_valid !== 1'b0)      begin bad++; $display("FAIL mrst_valid got=%b exp=0", ifid_valid); end
    total++; if (ifid_instr !== 32'h0)     begin bad++; $display("FAIL mrst_instr got=%h exp=0", ifid_instr); end
    total++; if (ifid_pc4 !== 32'h0)       begin bad++; $display("FAIL mrst_pc4 got=%h exp=0", ifid_pc4); end
    total++; if (pc_write !== 1'b0)        begin bad++; $display("FAIL mrst_write got=%b exp=0", pc_write); end
    total++; if (pc_next !== 32'h0)        begin bad++; $display("FAIL mrst_next got=%h exp=0", pc_next); end
    cyc(); cyc();
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (pc_next !== 32'h100)      begin bad++; $display("FAIL mrst_boot got=%h exp=100", pc_next); end
    cyc();
    @(negedge clk);
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin bad++; $display("FAIL mrst_first got=%b/%h exp=1/100", imem_req, imem_addr); end
    cyc();
    wait_ifid(ok);
    total++; if (ok !== 1'b1)              begin bad++; $display("FAIL mrst_fetch got=timeout exp=valid"); end
    total++; if (ifid_instr !== ~32'h100)  begin bad++; $display("FAIL mrst_instr2 got=%h exp=%h", ifid_instr, ~32'h100); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_boot();
    test_stall();
    test_redirect_wait();
    test_redirect_rvalid();
    test_drain_redirect();
    test_redirect_stall();
    test_wrap();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1, asynchronous active-low reset.
REQ-004 Port pc_in, input, 32, the current PC register value.
REQ-005 Port pc_next, output, 32, the next value presented to the PC register.
REQ-006 Port pc_write, output, 1; 1 means the PC loads pc_next, and 0 means the PC loads pc_next minus 8.
REQ-007 Port imem_req / imem_addr, output, 1 / 32, the instruction memory read request and its address.
REQ-008 Port imem_rvalid / imem_rdata, input, 1 / 32, the read return; latency is at least 1 cycle and is unbounded.
REQ-009 Port stall, input, 1, the hazard-unit hold for the IF/ID register.
REQ-010 Port redirect_valid / redirect_target, input, 1 / 32, the branch or jump redirect with its word-aligned target.
REQ-011 Port ifid_valid / ifid_instr / ifid_pc4, output, 1 / 32 / 32, the IF/ID register contents.

Function
REQ-012 The FSM SHALL have the states BOOT, REQ, WAIT and DRAIN.
- BOOT: drive pc_next=RESET_PC and pc_write=1 for one cycle, then go to REQ.
- REQ: assert imem_req with imem_addr=pc_in for one cycle, then go to WAIT.
- WAIT: hold until imem_rvalid.
- DRAIN: the outstanding response is discarded.
REQ-013 In WAIT, when imem_rvalid=1 and stall=0, the block SHALL, in the same edge:
- load IF/ID with ifid_instr=imem_rdata, ifid_pc4=pc_in+4, ifid_valid=1;
- drive pc_next=pc_in+4 with pc_write=1;
- go to REQ.
REQ-014 Hold encoding: whenever the PC must hold, the block SHALL drive pc_write=0 and pc_next=pc_in+8, so that the PC register keeps its value.
REQ-015 While stall=1, the IF/ID register SHALL hold, the PC SHALL hold, and no new imem_req SHALL issue.
REQ-016 A response that arrives while stall=1 SHALL be captured in a one-entry skid buffer and delivered to IF/ID on the first cycle with stall=0.
REQ-017 Redirect outside WAIT/DRAIN: redirect_valid=1 SHALL drive pc_next=redirect_target, pc_write=1, and ifid_valid=0 (flush) on the next edge, and the FSM SHALL go to REQ.
- This applies even when stall=1; redirect SHALL take priority over stall.
REQ-018 Redirect in WAIT: the block SHALL load the PC with the target, flush IF/ID, and go to DRAIN; in DRAIN the next imem_rvalid SHALL be dropped and the FSM SHALL go to REQ.
REQ-019 A redirect in the same cycle as imem_rvalid in WAIT SHALL drop that data and go directly to REQ.
REQ-020 A second redirect in DRAIN SHALL overwrite the PC target and SHALL remain in DRAIN.
REQ-021 At most one imem request SHALL be outstanding at any time.
REQ-022 PC arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC+4 SHALL wrap to 0.
REQ-023 The skid buffer SHALL be cleared by any redirect.

Reset
REQ-024 Reset assertion SHALL immediately set the FSM to BOOT and drive:
- imem_req=0;
- ifid_valid=0;
- ifid_instr=0;
- ifid_pc4=0;
- skid buffer empty;
- pc_write=0;
- pc_next=0.
REQ-025 A response still in flight when reset deasserts SHALL be ignored until BOOT completes.

Configuration
REQ-026 With FETCH_PERF_CNT_EN defined, the block SHALL add the 32-bit output counters cnt_fetch, cnt_stall and cnt_flush.
- They SHALL count delivered instructions, stalled cycles and redirects respectively.
- They SHALL saturate at all-ones and reset to 0.
REQ-027 Without FETCH_PERF_CNT_EN, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-028 A shared package SHALL hold the FSM state typedef, the constants INSTR_BYTES=4 and PC_HOLD_COMP=8, and the NOP encoding 32'h0000_0000.
REQ-029 The IF/ID register with its skid buffer SHALL be a sub-module named ifid_reg; the FSM and PC logic SHALL stay in fetch_ctrl.

Verification
REQ-030 Reset boot: release rst_n with RESET_PC=32'h100 and a 1-cycle memory -> the first imem_addr is 32'h100, and IF/ID shows pc4=32'h104, 32'h108, ... on successive fetches.
REQ-031 Stall: assert stall for 3 cycles while a response is returning -> the PC holds and pc_write=0 with pc_next=pc_in+8; the buffered instruction appears on the first unstalled cycle; no instruction is lost or duplicated.
REQ-032 Redirect in WAIT: pc_in=32'h40, memory latency 4, redirect to 32'h200 in cycle 2 -> the returning 32'h40 data is dropped, ifid_valid=0, and the next imem_addr is 32'h200.
REQ-033 Simultaneous redirect and rvalid: the data is dropped, REQ follows the next cycle, and no DRAIN is entered.
REQ-034 Wrap: pc_in=32'hFFFF_FFFC with a successful fetch -> pc_next=0 and ifid_pc4=0.
REQ-035 Mid-operation reset: assert rst_n low in WAIT -> all outputs are at reset values asynchronously, and after release the first request is RESET_PC.
